// File: rtl/dl_rshift_pipe_pkg.sv
// Shared shift definitions: shift-mode encodings and fill-bit selection helpers,
// common to the right shifter and sibling shift/rotate blocks.
package dl_rshift_pipe_pkg;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_MSB  = 1'b1
  } fill_sel_e;

  function automatic fill_sel_e fill_select(input logic arith);
    return (arith == SHIFT_ARITH) ? FILL_MSB : FILL_ZERO;
  endfunction

  function automatic logic fill_bit(input fill_sel_e sel, input logic msb);
    return (sel == FILL_MSB) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/dl_rshift_stage.sv
// One pipeline stage of the right shifter: conditional shift by 2^STAGE,
// registered together with its valid, remaining shift amount and mode.
module dl_rshift_stage
  import dl_rshift_pipe_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  parameter  int STAGE          = 0,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prev_valid,
  input  logic [NUM_BITS-1:0]       prev_data,
  input  logic [NUM_SHIFT_BITS-1:0] prev_shift,
  input  logic                      prev_arith,
  input  logic                      next_ready,
  output logic                      ready,
  output logic                      valid,
  output logic [NUM_BITS-1:0]       data,
  output logic [NUM_SHIFT_BITS-1:0] shift,
  output logic                      arith
);

  localparam int AMT = 1 << STAGE;

  logic                      valid_q, valid_d;
  logic [NUM_BITS-1:0]       data_q, data_d;
  logic [NUM_SHIFT_BITS-1:0] shift_q, shift_d;
  logic                      arith_q, arith_d;
  logic                      fill;
  logic [NUM_BITS-1:0]       shifted;

  // Fill comes from the incoming MSB, so the sign survives every stage.
  always_comb begin
    fill    = fill_bit(fill_select(prev_arith), prev_data[NUM_BITS-1]);
    shifted = prev_data;
    if (prev_shift[STAGE]) begin
      shifted = {{AMT{fill}}, prev_data[NUM_BITS-1:AMT]};
    end
  end

  assign ready = ~valid_q | next_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shift_d = shift_q;
    arith_d = arith_q;
    if (ready) begin
      valid_d = prev_valid;
      data_d  = shifted;
      shift_d = prev_shift;
      arith_d = prev_arith;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
      arith_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      arith_q <= arith_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign shift = shift_q;
  assign arith = arith_q;

endmodule

// File: rtl/dl_rshift_pipe.sv
// Pipelined logical/arithmetic right shifter, one log2 stage per register,
// with valid/ready on both sides and full throughput.
module dl_rshift_pipe
  import dl_rshift_pipe_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BITS-1:0]       a,
  input  logic [NUM_SHIFT_BITS-1:0] shift,
  input  logic                      arith,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out
);

  // Index k is the input side of stage k; index NUM_SHIFT_BITS is the output.
  logic                      valid_w [0:NUM_SHIFT_BITS];
  logic [NUM_BITS-1:0]       data_w  [0:NUM_SHIFT_BITS];
  logic [NUM_SHIFT_BITS-1:0] shift_w [0:NUM_SHIFT_BITS];
  logic                      arith_w [0:NUM_SHIFT_BITS];
  logic                      ready_w [0:NUM_SHIFT_BITS];
  logic                      unused_tail;

  assign valid_w[0] = in_valid;
  assign data_w[0]  = a;
  assign shift_w[0] = shift;
  assign arith_w[0] = arith;
  assign ready_w[NUM_SHIFT_BITS] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHIFT_BITS; gi++) begin : g_stage
      dl_rshift_stage #(
        .NUM_BITS (NUM_BITS),
        .STAGE    (gi)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .prev_valid (valid_w[gi]),
        .prev_data  (data_w[gi]),
        .prev_shift (shift_w[gi]),
        .prev_arith (arith_w[gi]),
        .next_ready (ready_w[gi+1]),
        .ready      (ready_w[gi]),
        .valid      (valid_w[gi+1]),
        .data       (data_w[gi+1]),
        .shift      (shift_w[gi+1]),
        .arith      (arith_w[gi+1])
      );
    end
  endgenerate

  // The final stage's shift amount and mode have no further consumer.
  assign unused_tail = ^{shift_w[NUM_SHIFT_BITS], arith_w[NUM_SHIFT_BITS]};

  assign in_ready  = ready_w[0];
  assign out_valid = valid_w[NUM_SHIFT_BITS];
  assign out       = data_w[NUM_SHIFT_BITS];

endmodule

// File: tb/tb_dl_rshift_pipe.sv
// Directed and randomized checks of dl_rshift_pipe (NUM_BITS=32, 5 stages).
module tb_dl_rshift_pipe;

  localparam int NB = 32;
  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] a;
  logic [NS-1:0] shift;
  logic          arith;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out;

  int vectors     = 0;
  int miscompares = 0;
  logic [NB-1:0] exp_q [$];

  always #5 clk = ~clk;

  dl_rshift_pipe #(.NUM_BITS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shift     (shift),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  function automatic logic [NB-1:0] ref_shift(input logic [NB-1:0] v, input logic [NS-1:0] s,
                                              input logic ar);
    if (ar) return NB'($signed(v) >>> s);
    return v >> s;
  endfunction

  // Samples handshakes at the falling edge, queues accepted operands' expected
  // results, then advances to just after the next rising edge.
  task automatic cycle(output bit in_fire, output bit rdy, output bit out_fire,
                       output logic [NB-1:0] od);
    @(negedge clk);
    rdy      = in_ready;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    od       = out;
    if (in_fire) exp_q.push_back(ref_shift(a, shift, arith));
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_operand();
    a     = $urandom;
    shift = NS'($urandom_range(0, NB - 1));
    arith = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; shift = '0; arith = 1'b0; out_ready = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out !== 32'h0) begin miscompares++; $display("FAIL reset_out: got %h expected 00000000", out); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [NB-1:0] ta [4];
    logic [NS-1:0] ts [4];
    logic          tr [4];
    logic [NB-1:0] te [4];
    int lat;
    ta[0] = 32'hF000_0000; ts[0] = 5'd4;  tr[0] = 1'b0; te[0] = 32'h0F00_0000;
    ta[1] = 32'h8000_0000; ts[1] = 5'd31; tr[1] = 1'b1; te[1] = 32'hFFFF_FFFF;
    ta[2] = 32'h8000_0000; ts[2] = 5'd31; tr[2] = 1'b0; te[2] = 32'h0000_0001;
    ta[3] = 32'h8000_0000; ts[3] = 5'd0;  tr[3] = 1'b1; te[3] = 32'h8000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = ta[i]; shift = ts[i]; arith = tr[i];
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lat_accept[%0d]: in_ready %b expected 1", i, in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      vectors++;
      if (lat != NS) begin miscompares++; $display("FAIL lat_cycles[%0d]: got %0d expected %0d", i, lat, NS); end
      vectors++;
      if (out !== te[i]) begin miscompares++; $display("FAIL lat_data[%0d]: got %h expected %h", i, out, te[i]); end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_nodup[%0d]: out_valid %b expected 0", i, out_valid); end
    end
    exp_q.delete();
  endtask

  task automatic test_stream();
    bit in_fire, rdy, out_fire;
    logic [NB-1:0] od, e;
    int sent = 0, got = 0, first_cyc = -1, last_cyc = 0, cyc = 0, stalls = 0;
    out_ready = 1'b1;
    while (got < 64 && cyc < 300) begin
      in_valid = (sent < 64);
      randomize_operand();
      cycle(in_fire, rdy, out_fire, od);
      if (in_fire) sent++;
      if (in_valid && !rdy) stalls++;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL stream_extra: got %h expected no output", od);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (od !== e) begin miscompares++; $display("FAIL stream_data[%0d]: got %h expected %h", got, od, e); end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 64) begin miscompares++; $display("FAIL stream_count: got %0d expected 64", got); end
    vectors++;
    if (last_cyc - first_cyc != 63) begin miscompares++; $display("FAIL stream_rate: span %0d expected 63", last_cyc - first_cyc); end
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit in_fire, rdy, out_fire;
    logic [NB-1:0] od, e, held;
    int acc = 0, cyc = 0, drained = 0;
    out_ready = 1'b0;
    rdy = 1'b1;
    while (cyc < 20) begin
      in_valid = 1'b1;
      randomize_operand();
      cycle(in_fire, rdy, out_fire, od);
      if (in_fire) acc++;
      if (!rdy) break;
      cyc++;
    end
    vectors++;
    if (acc != NS) begin miscompares++; $display("FAIL bp_accepts: got %0d expected %0d", acc, NS); end
    vectors++;
    if (rdy !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready: got %b expected 0", rdy); end
    held = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    for (int i = 0; i < 10; i++) begin
      cycle(in_fire, rdy, out_fire, od);
      vectors++;
      if (out_valid !== 1'b1 || od !== held || rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: out_valid %b out %h in_ready %b expected 1 %h 0", i, out_valid, od, rdy, held);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    randomize_operand();
    cycle(in_fire, rdy, out_fire, od);
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL bp_simul_ready: got %b expected 1", rdy); end
    in_valid = 1'b0;
    cyc = 0;
    while (1) begin
      if (out_fire) begin
        e = exp_q.pop_front();
        vectors++;
        if (od !== e) begin miscompares++; $display("FAIL bp_drain[%0d]: got %h expected %h", drained, od, e); end
        drained++;
      end
      if (exp_q.size() == 0 || cyc >= 20) break;
      cycle(in_fire, rdy, out_fire, od);
      cyc++;
    end
    vectors++;
    if (drained != NS + 1) begin miscompares++; $display("FAIL bp_drain_count: got %0d expected %0d", drained, NS + 1); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: out_valid %b expected 0", out_valid); end
    exp_q.delete();
  endtask

  task automatic test_random();
    bit in_fire, rdy, out_fire, exp_rdy;
    logic [NB-1:0] od, e;
    int ops_in = 0, ops_out = 0, occ = 0, cyc = 0, printed = 0;
    while (ops_out < 1000 && cyc < 20000) begin
      in_valid  = (ops_in < 1000) && ($urandom_range(0, 1) == 1);
      out_ready = 1'($urandom_range(0, 1));
      randomize_operand();
      cycle(in_fire, rdy, out_fire, od);
      exp_rdy = (occ < NS) || out_ready;
      vectors++;
      if (rdy !== exp_rdy) begin
        miscompares++;
        if (printed < 10) begin
          printed++;
          $display("FAIL rand_ready[cyc %0d]: got %b expected %b (occupancy %0d)", cyc, rdy, exp_rdy, occ);
        end
      end
      if (in_fire) ops_in++;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rand_extra: got %h expected no output", od);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (od !== e) begin
            miscompares++;
            if (printed < 10) begin
              printed++;
              $display("FAIL rand_data[%0d]: got %h expected %h", ops_out, od, e);
            end
          end
        end
        ops_out++;
      end
      occ = occ + int'(in_fire) - int'(out_fire);
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (ops_out != 1000) begin miscompares++; $display("FAIL rand_count: got %0d expected 1000", ops_out); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit in_fire, rdy, out_fire;
    logic [NB-1:0] od;
    int stale = 0, seen = 0, cyc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      randomize_operand();
      cycle(in_fire, rdy, out_fire, od);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
    vectors++;
    if (out !== 32'h0) begin miscompares++; $display("FAIL rmid_out: got %h expected 00000000", out); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(in_fire, rdy, out_fire, od);
      if (out_fire) stale++;
    end
    vectors++;
    if (stale != 0) begin miscompares++; $display("FAIL rmid_stale: got %0d outputs expected 0", stale); end
    in_valid = 1'b1; a = 32'h1234_5678; shift = 5'd8; arith = 1'b0;
    cycle(in_fire, rdy, out_fire, od);
    in_valid = 1'b0;
    while (cyc < 20) begin
      cycle(in_fire, rdy, out_fire, od);
      if (out_fire) begin seen++; break; end
      cyc++;
    end
    vectors++;
    if (seen != 1 || od !== 32'h0012_3456) begin
      miscompares++;
      $display("FAIL rmid_after: got %h (seen %0d) expected 00123456", od, seen);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
